// File: rtl/page_walker_pkg.sv
// Shared widths, PTE layout and walker state encoding for the two-level page-table walker.
package page_walker_pkg;

  localparam int level_bits        = 10;
  localparam int pte_bytes_log2    = 2;
  localparam int bit_count         = 32;
  localparam int page_adress_width = 2 * level_bits;
  localparam int ram_address_width = page_adress_width + level_bits + pte_bytes_log2;

  typedef struct packed {
    logic [page_adress_width-1:0]       ppn;
    logic [bit_count-page_adress_width-3:0] reserved;
    logic                               leaf;
    logic                               valid;
  } pte_t;

  typedef enum logic [2:0] {
    IDLE,
    L1_REQ,
    L2_REQ,
    FILL,
    FAULT
  } walk_state_t;

  // Byte address of a PTE: table page, index within the table, PTE-size zero padding.
  function automatic logic [ram_address_width-1:0] pte_addr(
    input logic [page_adress_width-1:0] ppn,
    input logic [level_bits-1:0]        idx
  );
    return {ppn, idx, {pte_bytes_log2{1'b0}}};
  endfunction

endpackage

// File: rtl/page_walker.sv
// Two-level hardware page-table walker: turns a TLB miss into one or two PTE reads
// and ends with either a single-cycle TLB fill or a single-cycle fault pulse.
module page_walker
  import page_walker_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          walk_valid,
  output logic                          walk_ready,
  input  logic [page_adress_width-1:0]  walk_vpn,
  input  logic [page_adress_width-1:0]  root_ppn,
  output logic                          mem_req,
  output logic [ram_address_width-1:0]  mem_addr,
  input  logic                          mem_ack,
  input  logic [bit_count-1:0]          mem_rdata,
  output logic                          tlb_write_enable,
  output logic [page_adress_width-1:0]  tlb_key,
  output logic [page_adress_width-1:0]  tlb_value,
  output logic                          fault,
  output logic [page_adress_width-1:0]  fault_vpn
);

  walk_state_t                   state, state_d;
  logic [page_adress_width-1:0]  vpn_q, vpn_d;
  logic [ram_address_width-1:0]  addr_d;
  logic [page_adress_width-1:0]  key_d, value_d, fvpn_d;
  pte_t                          pte;
  logic                          unused_reserved;

  assign pte             = pte_t'(mem_rdata);
  assign unused_reserved = ^pte.reserved;

  // Handshake and pulse outputs decode straight from state, so an asynchronous
  // reset drops mem_req in the same instant it forces IDLE.
  assign walk_ready       = (state == IDLE);
  assign mem_req          = (state == L1_REQ) || (state == L2_REQ);
  assign tlb_write_enable = (state == FILL);
  assign fault            = (state == FAULT);

  always_comb begin
    state_d = state;
    vpn_d   = vpn_q;
    addr_d  = mem_addr;
    key_d   = tlb_key;
    value_d = tlb_value;
    fvpn_d  = fault_vpn;
    case (state)
      IDLE: begin
        if (walk_valid) begin
          vpn_d   = walk_vpn;
          addr_d  = pte_addr(root_ppn, walk_vpn[page_adress_width-1 -: level_bits]);
          state_d = L1_REQ;
        end
      end
      L1_REQ: begin
        if (mem_ack) begin
          if (!pte.valid) begin
            fvpn_d  = vpn_q;
            state_d = FAULT;
          end else if (!pte.leaf) begin
            addr_d  = pte_addr(pte.ppn, vpn_q[level_bits-1:0]);
            state_d = L2_REQ;
          end else if (pte.ppn[level_bits-1:0] != '0) begin
            // A superpage must be aligned to the span the second level would cover.
            fvpn_d  = vpn_q;
            state_d = FAULT;
          end else begin
            key_d   = vpn_q;
            value_d = {pte.ppn[page_adress_width-1 -: level_bits], vpn_q[level_bits-1:0]};
            state_d = FILL;
          end
        end
      end
      L2_REQ: begin
        if (mem_ack) begin
          if (pte.valid && pte.leaf) begin
            key_d   = vpn_q;
            value_d = pte.ppn;
            state_d = FILL;
          end else begin
            fvpn_d  = vpn_q;
            state_d = FAULT;
          end
        end
      end
      FILL:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      vpn_q     <= '0;
      mem_addr  <= '0;
      tlb_key   <= '0;
      tlb_value <= '0;
      fault_vpn <= '0;
    end else begin
      state     <= state_d;
      vpn_q     <= vpn_d;
      mem_addr  <= addr_d;
      tlb_key   <= key_d;
      tlb_value <= value_d;
      fault_vpn <= fvpn_d;
    end
  end

endmodule

// File: tb/tb_page_walker.sv
// Bench for page_walker: directed vector table, wait-state/back-pressure and reset
// sequences, then randomized walks checked against an arithmetic page-table model.
module tb_page_walker;
  import page_walker_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        walk_valid = 1'b0;
  logic        walk_ready;
  logic [19:0] walk_vpn = '0;
  logic [19:0] root_ppn = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        twe;
  logic [19:0] tlb_key;
  logic [19:0] tlb_value;
  logic        fault;
  logic [19:0] fault_vpn;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  page_walker dut (
    .clk              (clk),
    .rst              (rst),
    .walk_valid       (walk_valid),
    .walk_ready       (walk_ready),
    .walk_vpn         (walk_vpn),
    .root_ppn         (root_ppn),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_ack          (mem_ack),
    .mem_rdata        (mem_rdata),
    .tlb_write_enable (twe),
    .tlb_key          (tlb_key),
    .tlb_value        (tlb_value),
    .fault            (fault),
    .fault_vpn        (fault_vpn)
  );

  typedef struct {
    logic [19:0] vpn;
    logic [19:0] root;
    logic [31:0] pte1;
    logic [31:0] pte2;
    int          w1;
    int          w2;
    bit          fill;
    logic [19:0] value;
    logic [31:0] addr1;
    logic [31:0] addr2;
    int          reads;
    int          lat;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [19:0] vpn, input logic [19:0] root,
                               input logic [31:0] pte1, input logic [31:0] pte2,
                               input int w1, input int w2, input bit fill,
                               input logic [19:0] value, input logic [31:0] addr1,
                               input logic [31:0] addr2, input int reads, input int lat);
    vec_t v;
    v.vpn = vpn; v.root = root; v.pte1 = pte1; v.pte2 = pte2; v.w1 = w1; v.w2 = w2;
    v.fill = fill; v.value = value; v.addr1 = addr1; v.addr2 = addr2;
    v.reads = reads; v.lat = lat;
    return v;
  endfunction

  // Reference: page tables as arithmetic on page numbers (4 KiB pages, 1024 PTEs of 4 bytes).
  function automatic vec_t model(input logic [19:0] vpn, input logic [19:0] root,
                                 input logic [31:0] pte1, input logic [31:0] pte2,
                                 input int w1, input int w2);
    vec_t e;
    int unsigned v, r, p1, p2;
    v = vpn; r = root;
    p1 = pte1 >> 12; p2 = pte2 >> 12;
    e = mkv(vpn, root, pte1, pte2, w1, w2, 1'b0, '0, r * 4096 + (v / 1024) * 4, '0, 1, 0);
    if (pte1 % 2 == 0) begin
      e.fill = 1'b0;
    end else if ((pte1 / 2) % 2 == 1) begin
      e.fill  = (p1 % 1024 == 0);
      e.value = 20'((p1 / 1024) * 1024 + v % 1024);
    end else begin
      e.reads = 2;
      e.addr2 = p1 * 4096 + (v % 1024) * 4;
      e.fill  = (pte2 % 4 == 3);
      e.value = 20'(p2);
    end
    e.lat = e.reads + w1 + ((e.reads == 2) ? w2 : 0) + 1;
    return e;
  endfunction

  // Starts at a negedge with the walker idle; returns at the negedge after the pulse.
  task automatic run_walk(input vec_t v, input bit hold, input logic [19:0] hvpn,
                          input logic [19:0] hroot);
    int  k, acks, waitc;
    bit  done;
    chk("ready_idle", {31'b0, walk_ready}, 32'd1);
    walk_valid = 1'b1; walk_vpn = v.vpn; root_ppn = v.root; mem_ack = 1'b0;
    @(posedge clk); #1;
    walk_valid = hold;
    walk_vpn   = hold ? hvpn  : 20'($urandom);
    root_ppn   = hold ? hroot : 20'($urandom);
    k = 0; acks = 0; waitc = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      k++;
      if (k > v.lat + 12) begin
        chk("walk_timeout", k, v.lat);
        break;
      end
      chk("ready_busy", {31'b0, walk_ready}, 32'd0);
      if (twe || fault) begin
        chk("fill_pulse", {31'b0, twe}, {31'b0, v.fill});
        chk("fault_pulse", {31'b0, fault}, {31'b0, !v.fill});
        chk("latency", k, v.lat);
        chk("reads", acks, v.reads);
        if (v.fill) begin
          chk("tlb_key", {12'b0, tlb_key}, {12'b0, v.vpn});
          chk("tlb_value", {12'b0, tlb_value}, {12'b0, v.value});
        end else begin
          chk("fault_vpn", {12'b0, fault_vpn}, {12'b0, v.vpn});
        end
        done = 1'b1;
      end else if (!mem_req) begin
        chk("mem_req", {31'b0, mem_req}, 32'd1);
      end
      if (mem_req) begin
        if (acks == 0) chk("addr_l1", mem_addr, v.addr1);
        else           chk("addr_l2", mem_addr, v.addr2);
        if (waitc < ((acks == 0) ? v.w1 : v.w2)) begin
          mem_ack = 1'b0; mem_rdata = $urandom; waitc++;
        end else begin
          mem_ack = 1'b1; mem_rdata = (acks == 0) ? v.pte1 : v.pte2; acks++; waitc = 0;
        end
      end else begin
        mem_ack = 1'($urandom); mem_rdata = $urandom;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0;
    chk("ready_after", {31'b0, walk_ready}, 32'd1);
    chk("no_pulse_after", {30'b0, twe, fault}, 32'd0);
    chk("req_after", {31'b0, mem_req}, 32'd0);
    if (v.fill) chk("key_hold", {12'b0, tlb_key}, {12'b0, v.vpn});
  endtask

  initial begin
    vec_t v;
    logic [31:0] base, p1, p2;

    tbl[0] = mkv(20'h01110, 20'h00100, 32'h00200001, 32'hAABF0003, 0, 0, 1'b1, 20'hAABF0,
                 32'h00100010, 32'h00200440, 2, 3);
    tbl[1] = mkv(20'hFFFFF, 20'h00100, 32'hAAC00003, 32'h0, 0, 0, 1'b1, 20'hAAFFF,
                 32'h00100FFC, 32'h0, 1, 2);
    tbl[2] = mkv(20'hFFFFF, 20'h00100, 32'hAAC01003, 32'h0, 0, 0, 1'b0, 20'h0,
                 32'h00100FFC, 32'h0, 1, 2);
    tbl[3] = mkv(20'h01110, 20'h00100, 32'h00200001, 32'h00000000, 0, 0, 1'b0, 20'h0,
                 32'h00100010, 32'h00200440, 2, 3);
    tbl[4] = mkv(20'h12345, 20'hABCDE, 32'hFFFFFFFE, 32'h0, 0, 0, 1'b0, 20'h0,
                 32'hABCDE120, 32'h0, 1, 2);
    tbl[5] = mkv(20'h01110, 20'h00100, 32'h00200001, 32'hAABF0001, 0, 0, 1'b0, 20'h0,
                 32'h00100010, 32'h00200440, 2, 3);
    tbl[6] = mkv(20'h01110, 20'h00100, 32'h00200001, 32'hAABF0003, 3, 3, 1'b1, 20'hAABF0,
                 32'h00100010, 32'h00200440, 2, 9);

    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, walk_ready}, 32'd1);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_twe", {31'b0, twe}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_key", {12'b0, tlb_key}, 32'd0);
    chk("rst_value", {12'b0, tlb_value}, 32'd0);
    chk("rst_fault_vpn", {12'b0, fault_vpn}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_walk(tbl[i], 1'b0, '0, '0);

    // Wait states with a second request held high throughout the first walk.
    run_walk(tbl[6], 1'b1, 20'h3C3C3, 20'h00ABC);
    run_walk(model(20'h3C3C3, 20'h00ABC, 32'h12345001, 32'h54321003, 0, 1), 1'b0, '0, '0);

    // Reset while the level-2 read is outstanding, with its ack arriving afterwards.
    walk_valid = 1'b1; walk_vpn = 20'h01110; root_ppn = 20'h00100;
    @(posedge clk); #1;
    walk_valid = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h00200001;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("rstmid_l2_req", {31'b0, mem_req}, 32'd1);
    chk("rstmid_l2_addr", mem_addr, 32'h00200440);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_req_async", {31'b0, mem_req}, 32'd0);
    chk("rstmid_ready_async", {31'b0, walk_ready}, 32'd1);
    chk("rstmid_addr", mem_addr, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hAABF0003;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstmid_no_pulse", {30'b0, twe, fault}, 32'd0);
      chk("rstmid_ready", {31'b0, walk_ready}, 32'd1);
      chk("rstmid_req", {31'b0, mem_req}, 32'd0);
    end
    mem_ack = 1'b0;

    for (int n = 0; n < 40; n++) begin
      base = $urandom;
      case ($urandom_range(0, 3))
        0:       p1 = base & ~32'h1;
        1:       p1 = (base | 32'h1) & ~32'h2;
        2:       p1 = (base & 32'hFFC00FFF) | 32'h3;
        default: p1 = base | 32'h1003;
      endcase
      base = $urandom;
      case ($urandom_range(0, 2))
        0:       p2 = base & ~32'h1;
        1:       p2 = (base | 32'h1) & ~32'h2;
        default: p2 = base | 32'h3;
      endcase
      v = model(20'($urandom), 20'($urandom), p1, p2, $urandom_range(0, 3), $urandom_range(0, 3));
      run_walk(v, 1'b0, '0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
